// File: rtl/wishbone_uart_fifo_slave.sv
// wishbone_uart_fifo_slave: Wishbone classic UART with TX/RX FIFOs, programmable baud divisor and sticky errors.
// Optional internal loopback (CTRL b2) is built when UART_LOOPBACK_EN is defined.
module wishbone_uart_fifo_slave #(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 115200,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        irq_o
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(CLK_FRE * 1000000 / BAUD_RATE);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic        req, wr, rd;
    logic [1:0]  a;
    logic [31:0] rdata, status;
    logic        tx_en, rx_en;
    logic [15:0] baud_div;
    logic        rx_ovr, frm_err, tx_ovf;
    logic        st_wr;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [TAW:0]   tx_cnt;
    logic           tx_full, tx_empty, tx_wr, tx_push, tx_pop, tx_ovf_set;
    logic [7:0]     tx_lvl;

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [RAW:0]   rx_cnt;
    logic           rx_full, rx_empty, rx_push, rx_pop, ovr_set, ferr_set;
    logic [7:0]     rx_lvl;

    state_t      tx_st, tx_st_n;
    logic [15:0] tx_bc, tx_bc_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic        tx_line, tx_q, tx_end, tx_go;

    state_t      rx_st, rx_st_n;
    logic [15:0] rx_bc, rx_bc_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_sh, rx_sh_n;
    logic        rx_s1, rx_s2, rx_prev, rx_in, rx_end, rx_half;

    logic unused;
    assign unused = &{1'b0, addr_i[31:4], addr_i[1:0], data_i[31:16]};

`ifdef UART_LOOPBACK_EN
    logic lpbk;
    assign rx_in     = lpbk ? tx_q : rx_s2;
    assign uart_tx_o = lpbk | tx_q;
`else
    localparam logic lpbk = 1'b0;
    assign rx_in     = rx_s2;
    assign uart_tx_o = tx_q;
`endif

    assign req   = cyc_i & stb_i & ~ack_o;
    assign a     = addr_i[3:2];
    assign wr    = req & we_i;
    assign rd    = req & ~we_i;
    assign st_wr = wr && a == 2'd1;

    assign tx_full    = tx_cnt == (TAW+1)'(TX_DEPTH);
    assign tx_empty   = tx_cnt == '0;
    assign tx_wr      = wr && a == 2'd0;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte
    assign tx_push    = tx_wr && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_wr && tx_full && !tx_pop;
    assign tx_lvl     = 32'(tx_cnt) > 32'd255 ? 8'hff : 8'(tx_cnt);

    assign rx_full  = rx_cnt == (RAW+1)'(RX_DEPTH);
    assign rx_empty = rx_cnt == '0;
    assign rx_pop   = rd && a == 2'd0 && !rx_empty;
    assign rx_lvl   = 32'(rx_cnt) > 32'd255 ? 8'hff : 8'(rx_cnt);

    assign status = {8'h0, rx_lvl, tx_lvl, 1'b0, tx_ovf, frm_err, rx_ovr,
                     rx_full, !rx_empty, tx_empty, tx_full};

    always_comb
        rdata = a == 2'd0 ? {24'h0, rx_empty ? 8'h0 : rx_mem[rx_rp]} :
                a == 2'd1 ? status :
                a == 2'd2 ? {29'h0, lpbk, rx_en, tx_en} : {16'h0, baud_div};

    assign tx_end = tx_bc == tx_div - 16'd1;
    assign tx_go  = tx_en && !tx_empty;

    always_comb begin
        tx_st_n  = tx_st;
        tx_bc_n  = tx_bc + 16'd1;
        tx_bit_n = tx_bit;
        tx_sh_n  = tx_sh;
        tx_div_n = tx_div;
        tx_pop   = 1'b0;
        tx_line  = 1'b1;
        case (tx_st)
            IDLE: begin
                tx_bc_n = '0;
                if (tx_go) begin
                    tx_pop   = 1'b1;
                    tx_sh_n  = tx_mem[tx_rp];
                    tx_div_n = baud_div;
                    tx_st_n  = START;
                end
            end
            START: begin
                tx_line = 1'b0;
                if (tx_end) begin
                    tx_bc_n  = '0;
                    tx_bit_n = '0;
                    tx_st_n  = DATA;
                end
            end
            DATA: begin
                tx_line = tx_sh[0];
                if (tx_end) begin
                    tx_bc_n  = '0;
                    tx_sh_n  = tx_sh >> 1;
                    tx_bit_n = tx_bit + 3'd1;
                    tx_st_n  = tx_bit == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (tx_end) begin
                    tx_bc_n = '0;
                    tx_st_n = IDLE;
                    // Chain straight into the next frame with no idle gap
                    if (tx_go) begin
                        tx_pop   = 1'b1;
                        tx_sh_n  = tx_mem[tx_rp];
                        tx_div_n = baud_div;
                        tx_st_n  = START;
                    end
                end
            end
        endcase
    end

    assign rx_end  = rx_bc == rx_div - 16'd1;
    assign rx_half = rx_bc == (rx_div >> 1) - 16'd1;

    always_comb begin
        rx_st_n  = rx_st;
        rx_bc_n  = rx_bc + 16'd1;
        rx_bit_n = rx_bit;
        rx_sh_n  = rx_sh;
        rx_div_n = rx_div;
        rx_push  = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        case (rx_st)
            IDLE: begin
                rx_bc_n = '0;
                if (rx_en && rx_prev && !rx_in) begin
                    rx_div_n = baud_div;
                    rx_st_n  = START;
                end
            end
            START: begin
                if (rx_half) begin
                    rx_bc_n  = '0;
                    rx_bit_n = '0;
                    rx_st_n  = rx_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_end) begin
                    rx_bc_n  = '0;
                    rx_sh_n  = {rx_in, rx_sh[7:1]};
                    rx_bit_n = rx_bit + 3'd1;
                    rx_st_n  = rx_bit == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (rx_end) begin
                    rx_st_n  = IDLE;
                    ferr_set = !rx_in;
                    ovr_set  = rx_in && rx_full && !rx_pop;
                    rx_push  = rx_in && (!rx_full || rx_pop);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp] <= data_i[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o    <= 1'b0;
            data_o   <= '0;
            irq_o    <= 1'b0;
            tx_en    <= 1'b1;
            rx_en    <= 1'b1;
`ifdef UART_LOOPBACK_EN
            lpbk     <= 1'b0;
`endif
            baud_div <= DIV_RST;
            rx_ovr   <= 1'b0;
            frm_err  <= 1'b0;
            tx_ovf   <= 1'b0;
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_cnt   <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_cnt   <= '0;
            tx_st    <= IDLE;
            tx_bc    <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_div   <= DIV_RST;
            tx_q     <= 1'b1;
            rx_st    <= IDLE;
            rx_bc    <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_div   <= DIV_RST;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            ack_o  <= req;
            data_o <= rd ? rdata : '0;
            if (wr && a == 2'd2) begin
                tx_en <= data_i[0];
                rx_en <= data_i[1];
`ifdef UART_LOOPBACK_EN
                lpbk  <= data_i[2];
`endif
            end
            if (wr && a == 2'd3) baud_div <= data_i[15:0] < 16'd16 ? 16'd16 : data_i[15:0];
            rx_ovr  <= (rx_ovr  & ~(st_wr & data_i[4])) | ovr_set;
            frm_err <= (frm_err & ~(st_wr & data_i[5])) | ferr_set;
            tx_ovf  <= (tx_ovf  & ~(st_wr & data_i[6])) | tx_ovf_set;
            irq_o   <= !rx_empty | rx_ovr | frm_err | tx_ovf;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
            tx_st   <= tx_st_n;
            tx_bc   <= tx_bc_n;
            tx_bit  <= tx_bit_n;
            tx_sh   <= tx_sh_n;
            tx_div  <= tx_div_n;
            tx_q    <= tx_line;
            rx_st   <= rx_st_n;
            rx_bc   <= rx_bc_n;
            rx_bit  <= rx_bit_n;
            rx_sh   <= rx_sh_n;
            rx_div  <= rx_div_n;
            rx_s1   <= uart_rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_in;
        end
    end
endmodule
